mgr_cntl_arb: RTL and testbench

- Parametrised successor to the manager NoC-to-MWC pass-through.
- Buffers NUM_CH NoC input channels (channel 0 = control path, channel 1 = data path by default) in per-channel FIFOs.
- Arbitrates them round-robin at packet granularity into a single registered MWC output.
- Consumes configuration packets on CFG_CH to program the WU-fetch start address, enable and stall registers, replacing the current hard-wired values.

---
 rtl/mgr_cntl_arb.sv | 225 ++++++++++++++++++++++
 tb/tb_mgr_cntl_arb.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgr_cntl_arb.sv
// Manager NoC-to-MWC controller: per-channel input FIFOs, packet-level round-robin
// arbitration into one registered MWC flit, and config-packet capture for WU fetch.
//
// state   | meaning
// ST_IDLE | no packet in flight; pick next SOM/SOM_EOM head round-robin
// ST_LOCK | multi-flit packet in flight on r_grant until its EOM is popped
module mgr_cntl_arb #(
  parameter int                 NUM_CH     = 2,
  parameter int                 DEPTH      = 8,
  parameter int                 DATA_W     = 64,
  parameter int                 TYPE_W     = 2,
  parameter int                 PTYPE_W    = 3,
  parameter int                 MGRID_W    = 6,
  parameter int                 ADDR_W     = 24,
  parameter int                 CFG_CH     = 0,
  parameter logic [PTYPE_W-1:0] CFG_PTYPE  = 3'd7,
  parameter logic               ENABLE_RST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_poweron_n,
  input  logic [NUM_CH-1:0]           noc__mcntl__valid,
  input  logic [2*NUM_CH-1:0]         noc__mcntl__cntl,
  input  logic [TYPE_W*NUM_CH-1:0]    noc__mcntl__type,
  input  logic [PTYPE_W*NUM_CH-1:0]   noc__mcntl__ptype,
  input  logic [DATA_W*NUM_CH-1:0]    noc__mcntl__data,
  input  logic [NUM_CH-1:0]           noc__mcntl__pvalid,
  input  logic [MGRID_W*NUM_CH-1:0]   noc__mcntl__mgrId,
  output logic [NUM_CH-1:0]           mcntl__noc__ready,
  output logic                        mcntl__mwc__valid,
  output logic [1:0]                  mcntl__mwc__cntl,
  output logic [TYPE_W-1:0]           mcntl__mwc__type,
  output logic [PTYPE_W-1:0]          mcntl__mwc__ptype,
  output logic [DATA_W-1:0]           mcntl__mwc__data,
  output logic                        mcntl__mwc__pvalid,
  output logic [MGRID_W-1:0]          mcntl__mwc__mgrId,
  input  logic                        mwc__mcntl__ready,
  output logic [ADDR_W-1:0]           mcntl__wuf__start_addr,
  output logic                        mcntl__wuf__enable,
  output logic                        xxx__wuf__stall,
  output logic [NUM_CH-1:0]           mcntl__err_orphan,
  input  logic [MGRID_W-1:0]          sys__mgr__mgrId
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int O_PV   = MGRID_W;
  localparam int O_DATA = MGRID_W + 1;
  localparam int O_PT   = O_DATA + DATA_W;
  localparam int O_TY   = O_PT + PTYPE_W;
  localparam int O_CN   = O_TY + TYPE_W;
  localparam int FLIT_W = O_CN + 2;
  localparam logic [PTR_W:0] RDY_TH = (PTR_W+1)'(DEPTH - 2);

  localparam logic [1:0] C_MOM = 2'b00;
  localparam logic [1:0] C_SOM = 2'b01;
  localparam logic [1:0] C_EOM = 2'b10;
  localparam logic [1:0] C_SE  = 2'b11;

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t              r_state, w_state_nxt;
  logic [CH_W-1:0]     r_grant, w_grant_nxt;
  logic [CH_W-1:0]     r_last_grant, w_last_nxt;
  logic                r_out_valid;
  logic [FLIT_W-1:0]   r_out_flit;
  logic [ADDR_W-1:0]   r_start_addr;
  logic                r_enable;
  logic                r_stall;

  logic [NUM_CH-1:0]   w_push, w_pop, w_empty, w_elig, w_orphan, w_cfg, w_fwd_pop;
  logic [FLIT_W-1:0]   w_head [NUM_CH];
  logic [1:0]          w_hcntl [NUM_CH];
  logic                w_load, w_fwd, w_found;
  logic [CH_W-1:0]     w_sel, w_idx;
  logic [FLIT_W-1:0]   w_fwd_flit;

  // Reserved input, kept visible only to document that it is intentionally ignored.
  logic w_unused;
  assign w_unused = ^sys__mgr__mgrId;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_wptr, r_rptr;
    logic              r_rdy, r_err;
    logic [PTR_W:0]    w_occ, w_occ_nxt;
    logic              w_full, w_is_cfg, w_in_pkt;
    logic [FLIT_W-1:0] w_din;

    assign w_din = {noc__mcntl__cntl[2*g +: 2],
                    noc__mcntl__type[TYPE_W*g +: TYPE_W],
                    noc__mcntl__ptype[PTYPE_W*g +: PTYPE_W],
                    noc__mcntl__data[DATA_W*g +: DATA_W],
                    noc__mcntl__pvalid[g],
                    noc__mcntl__mgrId[MGRID_W*g +: MGRID_W]};

    assign w_empty[g] = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                        (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_push[g]  = noc__mcntl__valid[g] && r_rdy && !w_full;
    assign w_head[g]  = r_mem[r_rptr[PTR_W-1:0]];
    assign w_hcntl[g] = w_head[g][O_CN +: 2];
    assign w_occ      = r_wptr - r_rptr;
    assign w_occ_nxt  = w_occ + {{PTR_W{1'b0}}, w_push[g]} - {{PTR_W{1'b0}}, w_pop[g]};

    // A channel is mid-packet exactly when it holds the lock.
    assign w_in_pkt = (r_state == ST_LOCK) && (r_grant == CH_W'(g));
    assign w_is_cfg = (g == CFG_CH) && (w_head[g][O_PT +: PTYPE_W] == CFG_PTYPE) &&
                      (w_hcntl[g] == C_SE);
    assign w_cfg[g]    = !w_empty[g] && w_is_cfg && !w_in_pkt;
    assign w_orphan[g] = !w_empty[g] && !w_in_pkt &&
                         ((w_hcntl[g] == C_MOM) || (w_hcntl[g] == C_EOM));
    assign w_elig[g]   = !w_empty[g] && !w_is_cfg &&
                         ((w_hcntl[g] == C_SOM) || (w_hcntl[g] == C_SE));
    assign w_pop[g]    = w_cfg[g] | w_orphan[g] | w_fwd_pop[g];

    assign mcntl__noc__ready[g] = r_rdy;
    assign mcntl__err_orphan[g] = r_err;

    always_ff @(posedge clk) begin
      if (w_push[g]) r_mem[r_wptr[PTR_W-1:0]] <= w_din;
    end

    always_ff @(posedge clk) begin
      if (!reset_poweron_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_rdy  <= 1'b0;
        r_err  <= 1'b0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + 1'b1;
        if (w_pop[g])  r_rptr <= r_rptr + 1'b1;
        // Two entries of headroom cover the flit that lands during the ready lag.
        r_rdy <= (w_occ_nxt <= RDY_TH);
        r_err <= r_err | w_orphan[g];
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last_grant;
    w_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_last_grant) + k) % NUM_CH);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_load = !r_out_valid || mwc__mcntl__ready;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last_grant;
    w_fwd_pop   = '0;
    w_fwd       = 1'b0;
    w_fwd_flit  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_load && w_found) begin
          w_fwd            = 1'b1;
          w_fwd_pop[w_sel] = 1'b1;
          w_fwd_flit       = w_head[w_sel];
          w_last_nxt       = w_sel;
          w_grant_nxt      = w_sel;
          if (w_hcntl[w_sel] == C_SOM) w_state_nxt = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (w_load && !w_empty[r_grant]) begin
          w_fwd              = 1'b1;
          w_fwd_pop[r_grant] = 1'b1;
          w_fwd_flit         = w_head[r_grant];
          if (w_hcntl[r_grant] == C_EOM) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_out_valid  <= 1'b0;
      r_out_flit   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      if (w_load) begin
        r_out_valid <= w_fwd;
        if (w_fwd) r_out_flit <= w_fwd_flit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron_n) begin
      r_start_addr <= '0;
      r_enable     <= ENABLE_RST;
      r_stall      <= 1'b0;
    end else if (w_cfg[CFG_CH]) begin
      r_start_addr <= w_head[CFG_CH][O_DATA +: ADDR_W];
      r_enable     <= w_head[CFG_CH][O_DATA + ADDR_W];
      r_stall      <= w_head[CFG_CH][O_DATA + ADDR_W + 1];
    end
  end

  assign mcntl__mwc__valid      = r_out_valid;
  assign mcntl__mwc__cntl       = r_out_flit[O_CN +: 2];
  assign mcntl__mwc__type       = r_out_flit[O_TY +: TYPE_W];
  assign mcntl__mwc__ptype      = r_out_flit[O_PT +: PTYPE_W];
  assign mcntl__mwc__data       = r_out_flit[O_DATA +: DATA_W];
  assign mcntl__mwc__pvalid     = r_out_flit[O_PV];
  assign mcntl__mwc__mgrId      = r_out_flit[MGRID_W-1:0];
  assign mcntl__wuf__start_addr = r_start_addr;
  assign mcntl__wuf__enable     = r_enable;
  assign xxx__wuf__stall        = r_stall;

endmodule

// File: tb/tb_mgr_cntl_arb.sv
// Directed bench for mgr_cntl_arb: expected flits are queued as stimulus is issued
// and checked in order as the MWC side accepts them.
module tb_mgr_cntl_arb;

  typedef logic [77:0] flit_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   noc_valid;
  logic [3:0]   noc_cntl;
  logic [3:0]   noc_type;
  logic [5:0]   noc_ptype;
  logic [127:0] noc_data;
  logic [1:0]   noc_pvalid;
  logic [11:0]  noc_mgrid;
  logic [1:0]   noc_ready;
  logic         mwc_valid;
  logic [1:0]   mwc_cntl;
  logic [1:0]   mwc_type;
  logic [2:0]   mwc_ptype;
  logic [63:0]  mwc_data;
  logic         mwc_pvalid;
  logic [5:0]   mwc_mgrid;
  logic         mwc_ready;
  logic [23:0]  start_addr;
  logic         wuf_enable;
  logic         wuf_stall;
  logic [1:0]   err_orphan;
  logic [5:0]   sys_mgrid = 6'h2A;

  int    checks = 0;
  int    failures = 0;
  int    acc [2];
  flit_t sb [$];
  flit_t cur_w;

  always #5 clk = ~clk;

  mgr_cntl_arb dut (
    .clk                    (clk),
    .reset_poweron_n        (rst_n),
    .noc__mcntl__valid      (noc_valid),
    .noc__mcntl__cntl       (noc_cntl),
    .noc__mcntl__type       (noc_type),
    .noc__mcntl__ptype      (noc_ptype),
    .noc__mcntl__data       (noc_data),
    .noc__mcntl__pvalid     (noc_pvalid),
    .noc__mcntl__mgrId      (noc_mgrid),
    .mcntl__noc__ready      (noc_ready),
    .mcntl__mwc__valid      (mwc_valid),
    .mcntl__mwc__cntl       (mwc_cntl),
    .mcntl__mwc__type       (mwc_type),
    .mcntl__mwc__ptype      (mwc_ptype),
    .mcntl__mwc__data       (mwc_data),
    .mcntl__mwc__pvalid     (mwc_pvalid),
    .mcntl__mwc__mgrId      (mwc_mgrid),
    .mwc__mcntl__ready      (mwc_ready),
    .mcntl__wuf__start_addr (start_addr),
    .mcntl__wuf__enable     (wuf_enable),
    .xxx__wuf__stall        (wuf_stall),
    .mcntl__err_orphan      (err_orphan),
    .sys__mgr__mgrId        (sys_mgrid)
  );

  assign cur_w = {mwc_cntl, mwc_type, mwc_ptype, mwc_data, mwc_pvalid, mwc_mgrid};

  function automatic flit_t mk_flit(input int ch, input logic [1:0] cn,
                                    input logic [2:0] pt, input logic [63:0] d);
    return {cn, 2'(ch + 1), pt, d, 1'b1, 6'(10 + ch)};
  endfunction

  function automatic logic [1:0] cntl_of(input int i, input int n);
    if (n == 1)     return 2'b11;
    if (i == 0)     return 2'b01;
    if (i == n - 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_flit(input int ch, input logic [1:0] cn, input logic [63:0] d,
                           input logic [2:0] pt);
    int n;
    bit done;
    noc_cntl[2*ch +: 2]   = cn;
    noc_type[2*ch +: 2]   = 2'(ch + 1);
    noc_ptype[3*ch +: 3]  = pt;
    noc_data[64*ch +: 64] = d;
    noc_pvalid[ch]        = 1'b1;
    noc_mgrid[6*ch +: 6]  = 6'(10 + ch);
    noc_valid[ch]         = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (noc_ready[ch] === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (done) acc[ch]++;
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL send_timeout ch=%0d observed=no_ready expected=ready", ch);
    end
  endtask

  task automatic send_pkt(input int ch, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) send_flit(ch, cntl_of(i, n), base + 64'(i), 3'd1);
    noc_valid[ch] = 1'b0;
  endtask

  task automatic push_pkt(input int ch, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) sb.push_back(mk_flit(ch, cntl_of(i, n), 3'd1, base + 64'(i)));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 128'(sb.size()), 128'd0);
  endtask

  // Output monitor: in-order scoreboard plus hold-stable check while stalled.
  flit_t held, exp_f;
  bit    held_v = 1'b0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        checks++;
        assert (mwc_valid === 1'b1 && cur_w === held) else begin
          failures++;
          $error("FAIL hold_stable observed=%0h/%0b expected=%0h/1", cur_w, mwc_valid, held);
        end
      end
      if (mwc_valid === 1'b1 && mwc_ready === 1'b1) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL sb_unexpected observed=%0h expected=none", cur_w);
        end
        if (sb.size() != 0) begin
          exp_f = sb.pop_front();
          checks++;
          assert (cur_w === exp_f) else begin
            failures++;
            $error("FAIL sb_flit observed=%0h expected=%0h", cur_w, exp_f);
          end
        end
      end
      held_v = (mwc_valid === 1'b1) && (mwc_ready !== 1'b1);
      held   = cur_w;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] pat;
  int acc_base;

  initial begin
    acc[0] = 0;
    acc[1] = 0;
    pat = 4'b1001;
    rst_n = 1'b0;
    mwc_ready = 1'b1;
    noc_valid = 2'b11;
    noc_cntl = 4'b0101;
    noc_type = '0;
    noc_ptype = '0;
    noc_data = '1;
    noc_pvalid = 2'b11;
    noc_mgrid = '0;

    // Reset with valid asserted on every channel
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mwc", {mwc_valid, cur_w}, 128'd0);
    chk("rst_ready", 128'(noc_ready), 128'd0);
    chk("rst_start_addr", 128'(start_addr), 128'd0);
    chk("rst_enable", 128'(wuf_enable), 128'd1);
    chk("rst_stall", 128'(wuf_stall), 128'd0);
    chk("rst_err", 128'(err_orphan), 128'd0);
    noc_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", 128'(noc_ready), 128'd3);

    // Config packet consumed on ch0, never forwarded
    send_flit(0, 2'b11, {38'd0, 1'b1, 1'b0, 24'h00ABCD}, 3'd7);
    noc_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("cfg_start_addr", 128'(start_addr), 128'h00ABCD);
    chk("cfg_enable", 128'(wuf_enable), 128'd0);
    chk("cfg_stall", 128'(wuf_stall), 128'd1);
    chk("cfg_no_fwd", 128'(mwc_valid), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("cfg_no_fwd_late", 128'(mwc_valid), 128'd0);

    // Arbitration: ch0 wins from reset, its packet stays contiguous
    push_pkt(0, 4, 64'h100);
    push_pkt(1, 1, 64'h200);
    fork
      send_pkt(0, 4, 64'h100);
      send_pkt(1, 1, 64'h200);
    join
    wait_drain();

    // Lone ch0 packet moves last_grant to ch0, so ch1 wins the repeated race
    push_pkt(0, 1, 64'h300);
    send_pkt(0, 1, 64'h300);
    wait_drain();
    push_pkt(1, 1, 64'h400);
    push_pkt(0, 4, 64'h500);
    fork
      send_pkt(0, 4, 64'h500);
      send_pkt(1, 1, 64'h400);
    join
    wait_drain();

    // Backpressure pattern 1,0,0,1 over a 6-flit ch1 packet
    push_pkt(1, 6, 64'h600);
    fork
      send_pkt(1, 6, 64'h600);
      begin
        for (int i = 0; i < 16; i++) begin
          mwc_ready = pat[i % 4];
          @(posedge clk);
          #1;
        end
        mwc_ready = 1'b1;
      end
    join
    wait_drain();

    // Fill with MWC stalled: 1 flit in output register + DEPTH-1 in FIFO, then ready drops
    push_pkt(1, 12, 64'h700);
    acc_base = acc[1];
    fork
      send_pkt(1, 12, 64'h700);
      begin
        mwc_ready = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("fill_ready_low", 128'(noc_ready[1]), 128'd0);
        chk("fill_accepted", 128'(acc[1] - acc_base), 128'd8);
        chk("fill_out_valid", 128'(mwc_valid), 128'd1);
        mwc_ready = 1'b1;
      end
    join
    wait_drain();

    // Orphan EOM on ch1 dropped, following packet intact
    send_flit(1, 2'b10, 64'hDEAD, 3'd1);
    noc_valid[1] = 1'b0;
    push_pkt(1, 3, 64'h800);
    send_pkt(1, 3, 64'h800);
    wait_drain();
    chk("orphan_err", 128'(err_orphan), 128'd2);

    // Reset after two of five flits have been forwarded
    mwc_ready = 1'b0;
    sb.push_back(mk_flit(0, 2'b01, 3'd1, 64'h900));
    sb.push_back(mk_flit(0, 2'b00, 3'd1, 64'h901));
    send_pkt(0, 5, 64'h900);
    mwc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    mwc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mwc_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_trailing", 128'(mwc_valid), 128'd0);
    chk("midrst_sb", 128'(sb.size()), 128'd0);
    chk("midrst_enable", 128'(wuf_enable), 128'd1);
    chk("midrst_start_addr", 128'(start_addr), 128'd0);
    chk("midrst_err", 128'(err_orphan), 128'd0);
    push_pkt(0, 2, 64'hA00);
    send_pkt(0, 2, 64'hA00);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
